// File: rtl/patch_scheduler.sv
// Walks a row-major image buffer in patch order; first beat 2 cycles after first rd_en, then 1 beat/cycle.
// Backpressure: out_ready low holds the head beat and throttles reads so held+inflight never exceeds 2.
module patch_scheduler #(
  parameter int IMG_WIDTH       = 16,
  parameter int IMG_HEIGHT      = 16,
  parameter int PATCH_SIZE      = 4,
  parameter int PATCH_SIZE_LOG2 = 2,
  parameter int PIXEL_WIDTH     = 24,
  parameter int ADDR_WIDTH      = 8,
  parameter int PATCH_IDX_WIDTH = 4,
  parameter int POS_IDX_WIDTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       output_taken,
  output logic [2:0]                 state,
  output logic                       rd_en,
  output logic [ADDR_WIDTH-1:0]      rd_addr,
  input  logic [PIXEL_WIDTH-1:0]     rd_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PIXEL_WIDTH-1:0]     out_pixel,
  output logic [PATCH_IDX_WIDTH-1:0] out_patch_idx,
  output logic [POS_IDX_WIDTH-1:0]   out_pos_idx,
  output logic                       out_patch_last,
  output logic                       out_frame_last
);
  localparam int L          = PATCH_SIZE_LOG2;
  localparam int PATCH_COLS = IMG_WIDTH / PATCH_SIZE;
  localparam int PATCH_ROWS = IMG_HEIGHT / PATCH_SIZE;

  localparam logic [L-1:0]          POS_MAX = L'(PATCH_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] PC_MAX  = ADDR_WIDTH'(PATCH_COLS - 1);
  localparam logic [ADDR_WIDTH-1:0] PR_MAX  = ADDR_WIDTH'(PATCH_ROWS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3
  } state_t;

  typedef struct packed {
    logic [PATCH_IDX_WIDTH-1:0] patch_idx;
    logic [POS_IDX_WIDTH-1:0]   pos_idx;
    logic                       patch_last;
    logic                       frame_last;
  } meta_t;

  typedef struct packed {
    logic [PIXEL_WIDTH-1:0] pixel;
    meta_t                  meta;
  } beat_t;

  state_t                     state_q, state_d;
  logic [L-1:0]               i_q, j_q;
  logic [ADDR_WIDTH-1:0]      pr_q, pc_q;
  logic [PATCH_IDX_WIDTH-1:0] patch_q;
  logic                       inflight_q;
  meta_t                      meta_inflight_q;
  beat_t                      buf_q [2];
  logic [1:0]                 held_q;

  meta_t                 issue_meta;
  beat_t                 new_beat;
  logic                  i_wrap, j_wrap, pc_wrap, pr_wrap;
  logic                  pop, push;
  logic [2:0]            occ;
  logic [ADDR_WIDTH-1:0] row, col;

  assign j_wrap  = (j_q == POS_MAX);
  assign i_wrap  = (i_q == POS_MAX);
  assign pc_wrap = (pc_q == PC_MAX);
  assign pr_wrap = (pr_q == PR_MAX);

  assign row     = (pr_q << L) | ADDR_WIDTH'(i_q);
  assign col     = (pc_q << L) | ADDR_WIDTH'(j_q);
  assign rd_addr = ADDR_WIDTH'(row * IMG_WIDTH + col);

  always_comb begin
    issue_meta            = '0;
    issue_meta.patch_idx  = patch_q;
    issue_meta.pos_idx    = POS_IDX_WIDTH'({i_q, j_q});
    issue_meta.patch_last = i_wrap && j_wrap;
    issue_meta.frame_last = pr_wrap && pc_wrap && i_wrap && j_wrap;
  end

  assign out_valid = (held_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign push      = inflight_q;
  assign new_beat  = {rd_data, meta_inflight_q};
  // Occupancy the buffer would reach if every read already issued lands
  assign occ       = {1'b0, held_q} - {2'b0, pop} + {2'b0, inflight_q};

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE:  if (en) state_d = RUN;
      RUN: begin
        rd_en = (occ < 3'd2);
        if (rd_en && issue_meta.frame_last) state_d = DRAIN;
      end
      DRAIN: if (pop && buf_q[0].meta.frame_last) state_d = DONE;
      DONE:  if (output_taken) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      i_q     <= '0;
      j_q     <= '0;
      pc_q    <= '0;
      pr_q    <= '0;
      patch_q <= '0;
    end else if (rd_en) begin
      if (j_wrap) begin
        j_q <= '0;
        i_q <= i_q + 1'b1;
        if (i_wrap) begin
          i_q     <= '0;
          patch_q <= issue_meta.frame_last ? '0 : patch_q + 1'b1;
          pc_q    <= pc_wrap ? '0 : pc_q + 1'b1;
          if (pc_wrap) pr_q <= pr_wrap ? '0 : pr_q + 1'b1;
        end
      end else begin
        j_q <= j_q + 1'b1;
      end
    end
  end

  // Head entry always lives in buf_q[0]; a pop shifts the second entry forward
  always_ff @(posedge clk) begin
    if (!reset) begin
      inflight_q      <= 1'b0;
      meta_inflight_q <= '0;
      held_q          <= 2'd0;
      buf_q[0]        <= '0;
      buf_q[1]        <= '0;
    end else begin
      inflight_q      <= rd_en;
      meta_inflight_q <= issue_meta;
      case ({push, pop})
        2'b10: begin
          if (held_q == 2'd0) buf_q[0] <= new_beat;
          else                buf_q[1] <= new_beat;
          held_q <= held_q + 1'b1;
        end
        2'b01: begin
          buf_q[0] <= buf_q[1];
          held_q   <= held_q - 1'b1;
        end
        2'b11: begin
          if (held_q == 2'd1) begin
            buf_q[0] <= new_beat;
          end else begin
            buf_q[0] <= buf_q[1];
            buf_q[1] <= new_beat;
          end
        end
        default: ;
      endcase
    end
  end

  assign state          = state_q;
  assign out_pixel      = buf_q[0].pixel;
  assign out_patch_idx  = buf_q[0].meta.patch_idx;
  assign out_pos_idx    = buf_q[0].meta.pos_idx;
  assign out_patch_last = buf_q[0].meta.patch_last;
  assign out_frame_last = buf_q[0].meta.frame_last;

endmodule

// File: tb/tb_patch_scheduler.sv
// Randomized-backpressure bench for patch_scheduler at 16x16/P4 and 8x8/P2, checked against a loop-nest patch-order model.
module tb_patch_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, out_ready, output_taken, en_a, en_b;
  bit   sel;

  logic [2:0]  state_a;  logic rd_en_a; logic [7:0] rd_addr_a; logic [23:0] rd_data_a;
  logic        valid_a;  logic [23:0] pixel_a; logic [3:0] patch_a, pos_a; logic pl_a, fl_a;
  logic [2:0]  state_b;  logic rd_en_b; logic [5:0] rd_addr_b; logic [23:0] rd_data_b;
  logic        valid_b;  logic [23:0] pixel_b; logic [3:0] patch_b; logic [1:0] pos_b; logic pl_b, fl_b;

  patch_scheduler dut_a (
    .clk(clk), .reset(reset), .en(en_a), .output_taken(output_taken), .state(state_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .out_valid(valid_a), .out_ready(out_ready), .out_pixel(pixel_a),
    .out_patch_idx(patch_a), .out_pos_idx(pos_a), .out_patch_last(pl_a), .out_frame_last(fl_a)
  );

  patch_scheduler #(
    .IMG_WIDTH(8), .IMG_HEIGHT(8), .PATCH_SIZE(2), .PATCH_SIZE_LOG2(1),
    .PIXEL_WIDTH(24), .ADDR_WIDTH(6), .PATCH_IDX_WIDTH(4), .POS_IDX_WIDTH(2)
  ) dut_b (
    .clk(clk), .reset(reset), .en(en_b), .output_taken(output_taken), .state(state_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .out_valid(valid_b), .out_ready(out_ready), .out_pixel(pixel_b),
    .out_patch_idx(patch_b), .out_pos_idx(pos_b), .out_patch_last(pl_b), .out_frame_last(fl_b)
  );

  // Image buffer: pixel value equals its address, garbage when not read
  always @(posedge clk) begin
    rd_data_a <= rd_en_a ? 24'(rd_addr_a) : 24'($urandom);
    rd_data_b <= rd_en_b ? 24'(rd_addr_b) : 24'($urandom);
  end

  logic [2:0]  o_state;
  logic        o_rd_en, o_valid, o_pl, o_fl;
  logic [7:0]  o_addr;
  logic [23:0] o_pixel;
  logic [3:0]  o_patch, o_pos;
  logic [34:0] o_bundle;
  assign o_state  = sel ? state_b : state_a;
  assign o_rd_en  = sel ? rd_en_b : rd_en_a;
  assign o_addr   = sel ? {2'b00, rd_addr_b} : rd_addr_a;
  assign o_valid  = sel ? valid_b : valid_a;
  assign o_pixel  = sel ? pixel_b : pixel_a;
  assign o_patch  = sel ? patch_b : patch_a;
  assign o_pos    = sel ? {2'b00, pos_b} : pos_a;
  assign o_pl     = sel ? pl_b : pl_a;
  assign o_fl     = sel ? fl_b : fl_a;
  assign o_bundle = {o_valid, o_pixel, o_patch, o_pos, o_pl, o_fl};

  typedef struct {
    int pixel;
    int patch;
    int pos;
    bit pl;
    bit fl;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic build(input bit which, input int w, input int h, input int p);
    exp_t e;
    int   n;
    n = 0;
    for (int pr = 0; pr < h / p; pr++)
      for (int pc = 0; pc < w / p; pc++)
        for (int i = 0; i < p; i++)
          for (int j = 0; j < p; j++) begin
            e.pixel = (pr * p + i) * w + pc * p + j;
            e.patch = pr * (w / p) + pc;
            e.pos   = i * p + j;
            e.pl    = (e.pos == p * p - 1);
            e.fl    = (n == w * h - 1);
            n++;
            if (which) exp_b.push_back(e);
            else       exp_a.push_back(e);
          end
  endtask

  // mode 0: ready=1; 1: 5-cycle stall at beat 37 then random ready;
  // 2: stray en/output_taken pulses mid-frame; 3: reset at beat 100
  task automatic run_frame(input int mode);
    int          nbeats, beat, issued, cyc, first_rd, first_vld, stall_left;
    bit          stalled_done, hold_prev;
    logic [34:0] saved;
    exp_t        e;
    nbeats = sel ? exp_b.size() : exp_a.size();
    beat = 0; issued = 0; cyc = 0; first_rd = -1; first_vld = -1;
    stall_left = 0; stalled_done = 0; hold_prev = 0; saved = '0;
    out_ready = 1'b1;
    if (sel) en_b = 1'b1; else en_a = 1'b1;
    @(posedge clk); #1;
    en_a = 1'b0; en_b = 1'b0;
    chk("run_entry_state", 64'(o_state), 64'd1);
    chk("first_addr", 64'(o_addr), 64'd0);
    while (beat < nbeats && cyc < 4000) begin
      if (mode == 1) begin
        if (beat == 37 && !stalled_done) begin
          stall_left   = 5;
          stalled_done = 1;
        end
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else if (stalled_done) out_ready = 1'($urandom_range(0, 1));
        else out_ready = 1'b1;
      end
      if (mode == 2) begin
        if (sel) en_b = (cyc == 10); else en_a = (cyc == 10);
        output_taken = (cyc == 20 || cyc == 40);
      end
      @(negedge clk);
      if (o_rd_en) begin
        issued++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (o_valid && first_vld < 0) first_vld = cyc;
      if (hold_prev) chk("stall_hold", 64'(o_bundle), 64'(saved));
      if (o_valid && out_ready) begin
        e = sel ? exp_b[beat] : exp_a[beat];
        chk("pixel", 64'(o_pixel), 64'(e.pixel));
        chk("patch_idx", 64'(o_patch), 64'(e.patch));
        chk("pos_idx", 64'(o_pos), 64'(e.pos));
        chk("patch_last", 64'(o_pl), 64'(e.pl));
        chk("frame_last", 64'(o_fl), 64'(e.fl));
        beat++;
      end
      chk("outstanding_le2", 64'((issued - beat) <= 2), 64'd1);
      hold_prev = o_valid && !out_ready;
      saved     = o_bundle;
      if (mode == 3 && beat == 100) break;
      @(posedge clk); #1;
      cyc++;
    end
    en_a = 1'b0; en_b = 1'b0; output_taken = 1'b0;
    if (mode == 3) begin
      reset = 1'b0;
      @(posedge clk); #1;
      chk("midreset_state", 64'(o_state), 64'd0);
      chk("midreset_valid", 64'(o_valid), 64'd0);
      chk("midreset_rd_en", 64'(o_rd_en), 64'd0);
      chk("midreset_pixel", 64'(o_pixel), 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("midreset_idle", 64'(o_state), 64'd0);
    end else begin
      chk("frame_beats", 64'(beat), 64'(nbeats));
      if (mode == 0) begin
        chk("first_rd_cycle", 64'(first_rd), 64'd0);
        chk("first_valid_latency", 64'(first_vld - first_rd), 64'd2);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      chk("done_state", 64'(o_state), 64'd3);
      chk("done_valid", 64'(o_valid), 64'd0);
      chk("done_rd_en", 64'(o_rd_en), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("done_hold", 64'(o_state), 64'd3);
      output_taken = 1'b1;
      @(posedge clk); #1;
      output_taken = 1'b0;
      chk("idle_after_taken", 64'(o_state), 64'd0);
    end
  endtask

  initial begin
    build(1'b0, 16, 16, 4);
    build(1'b1, 8, 8, 2);
    sel = 1'b0;
    reset = 1'b0; en_a = 1'b1; en_b = 1'b1; out_ready = 1'b1; output_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 64'(state_a), 64'd0);
    chk("rst_rd_en", 64'(rd_en_a), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr_a), 64'd0);
    chk("rst_valid", 64'(valid_a), 64'd0);
    chk("rst_outs", 64'({pixel_a, patch_a, pos_a, pl_a, fl_a}), 64'd0);
    chk("rst_state_b", 64'(state_b), 64'd0);
    en_a = 1'b0; en_b = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_rst", 64'(state_a), 64'd0);

    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);
    run_frame(0);
    sel = 1'b1;
    run_frame(0);
    run_frame(1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/patch_scheduler.md
Name: patch_scheduler

Overview:
- Sequencer that walks a row-major image buffer in patch order and emits a pixel stream tagged with patch and position indices.
- Feeds the patch-embedding datapath; the image buffer sits upstream, the embedding consumer downstream.
- Replaces bulk array copying with a 1-read-per-cycle address generator, a 2-entry output buffer and a valid/ready output handshake.
- Uses the same en / output_taken / state job protocol as the rest of the front end.

Parameters:
IMG_WIDTH, 16, image columns
IMG_HEIGHT, 16, image rows
PATCH_SIZE, 4, patch edge in pixels; must divide IMG_WIDTH and IMG_HEIGHT
PATCH_SIZE_LOG2, 2, log2(PATCH_SIZE)
PIXEL_WIDTH, 24, bits per pixel (3 x 8-bit channels)
ADDR_WIDTH, 8, width of the image buffer address, ceil(log2(IMG_WIDTH*IMG_HEIGHT))
PATCH_IDX_WIDTH, 4, width of out_patch_idx
POS_IDX_WIDTH, 4, width of out_pos_idx

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
en  in  1  start one frame; sampled only in IDLE
output_taken  in  1  acknowledge completion; sampled only in DONE
state  out  3  IDLE=0, RUN=1, DRAIN=2, DONE=3
rd_en  out  1  image buffer read strobe
rd_addr  out  ADDR_WIDTH  read address, row*IMG_WIDTH+col
rd_data  in  PIXEL_WIDTH  read data, valid exactly 1 cycle after rd_en
out_valid  out  1  output beat valid
out_ready  in  1  consumer accepts the beat
out_pixel  out  PIXEL_WIDTH  pixel data
out_patch_idx  out  PATCH_IDX_WIDTH  pr*(IMG_WIDTH/PATCH_SIZE)+pc
out_pos_idx  out  POS_IDX_WIDTH  i*PATCH_SIZE+j within the patch
out_patch_last  out  1  beat is the last position of its patch
out_frame_last  out  1  beat is the last pixel of the frame

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE.
  - rd_en, rd_addr, out_valid, out_pixel, all indices and last flags = 0.
  - Counters cleared, output buffer flushed, any in-flight read discarded.
  - Applies from any state, including mid-frame.
- Traversal order: patch row pr (outer), patch column pc, position row i, position column j (inner).
  - Pixel address = (pr*P+i)*IMG_WIDTH + pc*P + j, with P=PATCH_SIZE.
  - Index and coordinate arithmetic uses shifts/masks by PATCH_SIZE_LOG2.
- One frame is IMG_WIDTH*IMG_HEIGHT beats (256 at defaults).
- State transitions:
  - IDLE -> RUN when en=1. en outside IDLE is ignored.
  - RUN -> DRAIN in the cycle after the final read is issued.
  - DRAIN -> DONE on the handshake of the out_frame_last beat.
  - DONE -> IDLE when output_taken=1. output_taken outside DONE is ignored.
  - rd_en=0 in IDLE, DRAIN and DONE.
- Output buffer: 2 entries, FIFO order. out_* signals come from the head entry.
- Read credit rule: in RUN, rd_en=1 iff (held - pop) + inflight < 2.
  - held = entries currently in the buffer.
  - pop = out_valid && out_ready this cycle.
  - inflight = rd_en was asserted in the previous cycle.
- Timing:
  - rd_data is captured at the end of the cycle after rd_en.
  - First rd_en is in the first RUN cycle; first out_valid is 2 cycles later.
  - With out_ready held at 1, steady-state throughput is 1 beat/cycle.
- Handshake:
  - A beat transfers when out_valid && out_ready.
  - While out_valid && !out_ready, all out_* hold stable.
  - out_valid never drops without a transfer.
  - No beat is lost or duplicated.
- Tags and flags:
  - Indices and flags are computed at issue and travel through the buffer with the data.
  - out_patch_last=1 iff pos_idx==P*P-1.
  - out_frame_last=1 only on beat IMG_WIDTH*IMG_HEIGHT-1.
- Simultaneous events:
  - A push and a pop in the same cycle leave occupancy unchanged.
  - reset=0 overrides en and output_taken.

Test Plan:
- Hold reset=0 for 2 cycles with en=1 -> state=0, rd_en=0, out_valid=0, all out_* = 0.
- Memory model returns rd_data=address; en pulse, out_ready=1 -> 256 beats with these values:
  - beats 0-4 = 0,1,2,3,16; beat 15 = 51 with patch_last=1.
  - beat 16 = 4 with patch_idx=1; beat 64 = 64 with patch_idx=4.
  - beat 255 = 255 with frame_last=1.
  - First out_valid 2 cycles after first rd_en; state=3 after the last beat; output_taken -> state=0.
- out_ready=0 for 5 cycles at beat 37, then random toggling -> out_pixel/indices stable while stalled; sequence identical to the previous test; never more than 2 (held+inflight) outstanding.
- en pulsed during RUN and output_taken pulsed during RUN -> no restart, no state change, beat sequence unchanged.
- reset=0 at beat 100 -> next cycle state=0, out_valid=0; new en restarts at address 0 with patch_idx=0 and pos_idx=0.
- IMG_WIDTH=IMG_HEIGHT=8, PATCH_SIZE=2, PATCH_SIZE_LOG2=1 -> 64 beats:
  - first beats 0,1,8,9 (patch 0), then 2,3,10,11 (patch 1).
  - beat 63 = 63 with frame_last=1.
